uart_pkt_decoder: RTL and testbench

//  Parses the UART RX byte stream into command packets and forwards verified payloads
//  to per-destination consumers. Sits between uart_rx and the destination FIFOs/SPI masters.

---
 rtl/uart_pkt_decoder_pkg.sv | 17 +
 rtl/uart_pkt_decoder_pkt_buf_ram.sv | 20 ++
 rtl/uart_pkt_decoder.sv | 192 +++++++++++++++++++
 tb/tb_uart_pkt_decoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_decoder_pkg.sv
// Shared constants for the UART packet decoder:
// destination count, framing bytes and FSM encoding.
package uart_pkt_decoder_pkg;

  localparam int         NUM_SOURCES = 4;
  localparam logic [7:0] PREFIX_DEF  = 8'hDD;
  localparam logic [7:0] BOARD_DEF   = 8'h01;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_DEST    = 3'd2;
  localparam logic [2:0] S_LEN     = 3'd3;
  localparam logic [2:0] S_PAYLOAD = 3'd4;
  localparam logic [2:0] S_SUM     = 3'd5;
  localparam logic [2:0] S_DRAIN   = 3'd6;

endpackage

// File: rtl/uart_pkt_decoder_pkt_buf_ram.sv
// 256x8 simple dual-port payload buffer,
// one write port and one registered read port.
module pkt_buf_ram (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] waddr,
  input  logic [7:0] wdata,
  input  logic       re,
  input  logic [7:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [256];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_pkt_decoder.sv
// Frame parser: PREFIX BOARD DEST LEN payload SUM.
// Payload is buffered and released only after SUM matches.
module uart_pkt_decoder
  import uart_pkt_decoder_pkg::*;
#(
  parameter int         NUM_DEST    = NUM_SOURCES,
  parameter logic [7:0] PREFIX      = PREFIX_DEF,
  parameter logic [7:0] BOARD_ADDR  = BOARD_DEF,
  parameter int         TIMEOUT_CYC = 20000,
  localparam int DW = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1,
  localparam int TW = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_dest,
  output logic          out_last,
  output logic          pkt_ok,
  output logic          err_sum,
  output logic          err_addr,
  output logic          err_tout,
  output logic          rx_drop
);

  logic [2:0]    state_q, state_d;
  logic          bad_q, bad_d;
  logic [DW-1:0] dest_q, dest_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          ok_q, ok_d;
  logic          esum_q, esum_d;
  logic          eaddr_q, eaddr_d;
  logic          etout_q, etout_d;
  logic          drop_q, drop_d;

  logic       we, re, hs, last, in_frame;
  logic [7:0] raddr, rdata;

  pkt_buf_ram u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (cnt_q),
    .wdata (rx_data),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign out_valid = (state_q == S_DRAIN);
  assign last      = (cnt_q == len_q - 8'd1);
  assign hs        = out_valid & out_ready;
  assign out_last  = out_valid & last;
  assign out_data  = out_valid ? rdata : 8'h00;
  assign out_dest  = out_valid ? dest_q : '0;
  assign in_frame  = (state_q != S_IDLE) && (state_q != S_DRAIN);

  assign pkt_ok   = ok_q;
  assign err_sum  = esum_q;
  assign err_addr = eaddr_q;
  assign err_tout = etout_q;
  assign rx_drop  = drop_q;

  always_comb begin
    state_d = state_q;
    bad_d   = bad_q;
    dest_d  = dest_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    tcnt_d  = '0;
    ok_d    = 1'b0;
    esum_d  = 1'b0;
    eaddr_d = 1'b0;
    etout_d = 1'b0;
    drop_d  = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    raddr   = cnt_q + 8'd1;

    // an arriving byte always beats timeout expiry
    if (in_frame && !rx_valid) begin
      if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
        etout_d = 1'b1;
        state_d = S_IDLE;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end

    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (rx_valid && rx_data == PREFIX) state_d = S_ADDR;
      end
      (state_q == S_ADDR): begin
        if (rx_valid) begin
          bad_d   = (rx_data != BOARD_ADDR);
          state_d = S_DEST;
        end
      end
      (state_q == S_DEST): begin
        if (rx_valid) begin
          dest_d  = rx_data[DW-1:0];
          bad_d   = bad_q | (rx_data >= 8'(NUM_DEST));
          state_d = S_LEN;
        end
      end
      (state_q == S_LEN): begin
        if (rx_valid) begin
          len_d   = rx_data;
          sum_d   = 8'h00;
          cnt_d   = 8'h00;
          state_d = (rx_data == 8'h00) ? S_SUM : S_PAYLOAD;
        end
      end
      (state_q == S_PAYLOAD): begin
        if (rx_valid) begin
          we    = 1'b1;
          sum_d = sum_q + rx_data;
          cnt_d = cnt_q + 8'd1;
          if (last) state_d = S_SUM;
        end
      end
      (state_q == S_SUM): begin
        if (rx_valid) begin
          state_d = S_IDLE;
          if (bad_q) begin
            eaddr_d = 1'b1;
          end else if (rx_data != sum_q) begin
            esum_d = 1'b1;
          end else begin
            ok_d  = 1'b1;
            cnt_d = 8'h00;
            if (len_q != 8'h00) begin
              re      = 1'b1;
              raddr   = 8'h00;
              state_d = S_DRAIN;
            end
          end
        end
      end
      (state_q == S_DRAIN): begin
        drop_d = rx_valid;
        if (hs) begin
          if (last) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
            re    = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      bad_q   <= 1'b0;
      dest_q  <= '0;
      len_q   <= 8'h00;
      cnt_q   <= 8'h00;
      sum_q   <= 8'h00;
      tcnt_q  <= '0;
      ok_q    <= 1'b0;
      esum_q  <= 1'b0;
      eaddr_q <= 1'b0;
      etout_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bad_q   <= bad_d;
      dest_q  <= dest_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      tcnt_q  <= tcnt_d;
      ok_q    <= ok_d;
      esum_q  <= esum_d;
      eaddr_q <= eaddr_d;
      etout_q <= etout_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_uart_pkt_decoder.sv
// Directed bench for uart_pkt_decoder: framing,
// errors, timeout, backpressure, drops and reset.
module tb_uart_pkt_decoder;

  localparam int TOUT = 64;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_dest;
  logic       out_last;
  logic       pkt_ok, err_sum, err_addr, err_tout, rx_drop;

  logic rdy_fix, rand_rdy, rnd, clr;

  int n_assert = 0;
  int n_fail   = 0;

  int n_ok, n_sum, n_addr, n_tout, n_drop, n_valid, stab_err;
  logic [10:0] cap [$];
  logic [7:0]  fr [$];
  logic [7:0]  exp_q [$];
  logic        prev_stall;
  logic [10:0] prev_word;

  always #5 clk = ~clk;

  assign out_ready = rand_rdy ? rnd : rdy_fix;

  always @(posedge clk) rnd <= 1'($urandom);

  uart_pkt_decoder #(.TIMEOUT_CYC(TOUT)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dest  (out_dest),
    .out_last  (out_last),
    .pkt_ok    (pkt_ok),
    .err_sum   (err_sum),
    .err_addr  (err_addr),
    .err_tout  (err_tout),
    .rx_drop   (rx_drop)
  );

  always @(negedge clk) begin
    if (clr) begin
      cap.delete();
      n_ok <= 0; n_sum <= 0; n_addr <= 0; n_tout <= 0;
      n_drop <= 0; n_valid <= 0; stab_err <= 0;
      prev_stall <= 1'b0;
    end else begin
      n_ok   <= n_ok + int'(pkt_ok);
      n_sum  <= n_sum + int'(err_sum);
      n_addr <= n_addr + int'(err_addr);
      n_tout <= n_tout + int'(err_tout);
      n_drop <= n_drop + int'(rx_drop);
      n_valid <= n_valid + int'(out_valid);
      if (prev_stall && out_valid &&
          {out_last, out_dest, out_data} !== prev_word)
        stab_err <= stab_err + 1;
      if (out_valid && out_ready)
        cap.push_back({out_last, out_dest, out_data});
      prev_stall <= out_valid & ~out_ready;
      prev_word  <= {out_last, out_dest, out_data};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    @(negedge clk);
    #1 clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b; rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_frame();
    foreach (fr[i]) send_byte(fr[i]);
  endtask

  task automatic check_pkt(input string tag, input logic [1:0] d);
    chk({tag, "_count"}, 32'(cap.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(cap[i]),
          32'({(i == exp_q.size() - 1), d, exp_q[i]}));
  endtask

  initial begin
    n_rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    rdy_fix = 1'b1; rand_rdy = 1'b0; clr = 1'b1;
    cyc(3);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_pulses", 32'({pkt_ok, err_sum, err_addr, err_tout, rx_drop}), 0);
    chk("rst_data", 32'({out_last, out_dest, out_data}), 0);
    n_rst = 1'b1;
    clr = 1'b0;
    cyc(2);

    // good frame, ready held high
    clear();
    fr = '{8'hDD, 8'h01, 8'h00, 8'h06, 8'h01, 8'h02, 8'h03,
           8'h04, 8'h05, 8'h06, 8'h15};
    send_frame();
    cyc(20);
    chk("good_ok", 32'(n_ok), 1);
    chk("good_errs", 32'(n_sum + n_addr + n_tout), 0);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    check_pkt("good", 2'd0);

    // bad checksum
    clear();
    fr[10] = 8'h16;
    send_frame();
    cyc(10);
    chk("sum_err", 32'(n_sum), 1);
    chk("sum_noout", 32'(n_valid), 0);
    chk("sum_nook", 32'(n_ok), 0);

    // wrong board address wins over a matching sum
    clear();
    fr = '{8'hDD, 8'h02, 8'h00, 8'h01, 8'hAA, 8'hAA};
    send_frame();
    cyc(5);
    chk("board_err", 32'(n_addr), 1);
    chk("board_only", 32'(n_sum + n_ok), 0);

    // destination out of range
    clear();
    fr = '{8'hDD, 8'h01, 8'h04, 8'h01, 8'hAA, 8'hAA};
    send_frame();
    cyc(5);
    chk("dest_err", 32'(n_addr), 1);
    chk("dest_noout", 32'(n_valid), 0);

    // zero-length frame
    clear();
    fr = '{8'hDD, 8'h01, 8'h03, 8'h00, 8'h00};
    send_frame();
    cyc(5);
    chk("zlen_ok", 32'(n_ok), 1);
    chk("zlen_noout", 32'(n_valid), 0);

    // timeout, then recovery
    clear();
    fr = '{8'hDD, 8'h01, 8'h00, 8'h06, 8'h01, 8'h02};
    send_frame();
    cyc(TOUT - 10);
    chk("tout_early", 32'(n_tout), 0);
    cyc(20);
    chk("tout_fire", 32'(n_tout), 1);
    chk("tout_noerr", 32'(n_sum + n_addr + n_ok), 0);
    fr = '{8'hDD, 8'h01, 8'h03, 8'h01, 8'h05, 8'h05};
    send_frame();
    cyc(10);
    chk("recov_ok", 32'(n_ok), 1);
    exp_q = '{8'h05};
    check_pkt("recov", 2'd3);

    // random backpressure
    clear();
    rand_rdy = 1'b1;
    fr = '{8'hDD, 8'h01, 8'h02, 8'h08, 8'h10, 8'h20, 8'h30,
           8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h40};
    send_frame();
    cyc(120);
    rand_rdy = 1'b0;
    chk("bp_ok", 32'(n_ok), 1);
    chk("bp_stable", 32'(stab_err), 0);
    chk("bp_idle", 32'(out_valid), 0);
    exp_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    check_pkt("bp", 2'd2);

    // byte during drain is dropped
    clear();
    rdy_fix = 1'b0;
    fr = '{8'hDD, 8'h01, 8'h01, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h16};
    send_frame();
    cyc(3);
    chk("drain_hold", 32'(out_valid), 1);
    send_byte(8'h55);
    cyc(3);
    rdy_fix = 1'b1;
    cyc(10);
    chk("drain_drop", 32'(n_drop), 1);
    chk("drain_stable", 32'(stab_err), 0);
    exp_q = '{8'hA1, 8'hB2, 8'hC3};
    check_pkt("drain", 2'd1);

    // reset mid payload
    clear();
    fr = '{8'hDD, 8'h01, 8'h00, 8'h06, 8'h01, 8'h02};
    send_frame();
    n_rst = 1'b0;
    cyc(2);
    chk("rst_mid_valid", 32'(out_valid), 0);
    n_rst = 1'b1;
    cyc(1);
    fr = '{8'hDD, 8'h01, 8'h02, 8'h03, 8'h09, 8'h08, 8'h07, 8'h18};
    send_frame();
    cyc(10);
    chk("rst_mid_ok", 32'(n_ok), 1);
    exp_q = '{8'h09, 8'h08, 8'h07};
    check_pkt("rst_mid", 2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
